// File: rtl/qdec_mvd_egk_dec.sv
// qdec_mvd_egk_dec
//   MVD syntax decoder for the CABAC front end. It issues one bin request at a
//   time to the arithmetic decoder. For NUM_COMP components it decodes:
//   - abs_mvd_greater0/1 flags (context-coded),
//   - abs_mvd_minus2 as an EGk bypass code,
//   - mvd_sign_flag (bypass).
//   It then presents the signed MVDs with a one-cycle valid pulse.
//
//   Optional feature macro: MVD_PREFIX_CHECK_EN
//     Enables the EGk prefix overflow check and drives mvd_err.
//     Without it, mvd_err is tied 0 and acc wraps modulo 2^MVD_W.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   mvd_start   start pulse, accepted only in IDLE
//   ctx_addr    context address of the current request
//   dec_run     one-cycle bin request
//   ep_mode     1 = bypass bin, 0 = context bin
//   dec_rdy     decoder can accept a request
//   bin         decoded bin
//   bin_vld     bin valid
//   mvd         packed signed MVDs (comp0 in LSBs), written only on completion
//   mvd_vld     one-cycle pulse: mvd updated
//   mvd_done    one-cycle completion pulse, cycle after mvd_vld
//   mvd_err     sticky prefix overflow flag
module qdec_mvd_egk_dec #(
    parameter int NUM_COMP   = 2,
    parameter int MVD_W      = 16,
    parameter int EGK_ORDER  = 1,
    parameter int MAX_PREFIX = 15,
    parameter int CTX_W      = 10,
    parameter int CTX_GT0    = 0,
    parameter int CTX_GT1    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mvd_start,
    output logic [CTX_W-1:0]          ctx_addr,
    output logic                      dec_run,
    output logic                      ep_mode,
    input  logic                      dec_rdy,
    input  logic                      bin,
    input  logic                      bin_vld,
    output logic [NUM_COMP*MVD_W-1:0] mvd,
    output logic                      mvd_vld,
    output logic                      mvd_done,
    output logic                      mvd_err
);

    typedef enum logic [2:0] {IDLE, GT0, GT1, PFX, SFX, SIGN, OUT} state_t;

    localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;
    localparam int KW = 8;

    state_t                      state;
    logic [CW-1:0]               c;
    logic                        pending;
    logic [NUM_COMP-1:0]         gt0;
    logic [NUM_COMP-1:0]         gt1;
    logic [MVD_W-1:0]            acc;
    logic [KW-1:0]               k;
    logic [NUM_COMP*MVD_W-1:0]   res;
    logic                        out_q;
`ifdef MVD_PREFIX_CHECK_EN
    logic [KW-1:0]               pcnt;
`endif

    logic                        take;
    logic                        bin_state;
    logic [NUM_COMP-1:0]         gt0_upd;
    logic [NUM_COMP-1:0]         gt1_upd;
    logic                        fs_found;
    logic [CW-1:0]               fs_idx;
    logic                        nx_found;
    logic [CW-1:0]               nx_idx;
    logic [MVD_W-1:0]            abs_v;
    logic [MVD_W-1:0]            sgn_v;

    assign take      = pending & bin_vld;
    assign bin_state = (state == GT0) || (state == GT1) || (state == PFX) ||
                       (state == SFX) || (state == SIGN);

    // Flag vectors include the bin being consumed this cycle. This lets the
    // component search pick the next target without an extra state.
    // fs_* is the first component with gt0 set.
    // nx_* is the first component after c with gt0 set.
    always_comb begin
        gt0_upd = gt0;
        gt1_upd = gt1;
        if (state == GT0) gt0_upd[c] = bin;
        if (state == GT1) gt1_upd[c] = bin;
        fs_found = 1'b0;
        fs_idx   = '0;
        nx_found = 1'b0;
        nx_idx   = '0;
        for (int unsigned i = 0; i < NUM_COMP; i++) begin
            if (gt0_upd[i] && !fs_found) begin
                fs_found = 1'b1;
                fs_idx   = CW'(i);
            end
            if (gt0_upd[i] && (i > 32'(c)) && !nx_found) begin
                nx_found = 1'b1;
                nx_idx   = CW'(i);
            end
        end
        abs_v = gt0[c] ? (gt1[c] ? acc + MVD_W'(2) : MVD_W'(1)) : '0;
        sgn_v = bin ? ('0 - abs_v) : abs_v;
    end

`ifndef MVD_PREFIX_CHECK_EN
    assign mvd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            c        <= '0;
            pending  <= 1'b0;
            gt0      <= '0;
            gt1      <= '0;
            acc      <= '0;
            k        <= '0;
            res      <= '0;
            out_q    <= 1'b0;
            dec_run  <= 1'b0;
            ep_mode  <= 1'b0;
            ctx_addr <= '0;
            mvd      <= '0;
            mvd_vld  <= 1'b0;
            mvd_done <= 1'b0;
`ifdef MVD_PREFIX_CHECK_EN
            pcnt     <= '0;
            mvd_err  <= 1'b0;
`endif
        end else begin
            dec_run  <= 1'b0;
            mvd_vld  <= 1'b0;
            out_q    <= 1'b0;
            mvd_done <= out_q;
            if (take) pending <= 1'b0;

            // Request and consume are mutually exclusive through pending.
            // This gives the two-cycle minimum per bin.
            if (bin_state && !pending && dec_rdy) begin
                dec_run  <= 1'b1;
                pending  <= 1'b1;
                ep_mode  <= (state == PFX) || (state == SFX) || (state == SIGN);
                ctx_addr <= (state == GT1) ? CTX_W'(CTX_GT1) : CTX_W'(CTX_GT0);
            end

            case (state)
                IDLE: begin
                    if (mvd_start) begin
                        state <= GT0;
                        c     <= '0;
                        gt0   <= '0;
                        gt1   <= '0;
                        res   <= '0;
`ifdef MVD_PREFIX_CHECK_EN
                        mvd_err <= 1'b0;
`endif
                    end
                end
                GT0: begin
                    if (take) begin
                        gt0[c] <= bin;
                        if (32'(c) == NUM_COMP - 1) begin
                            c     <= fs_idx;
                            state <= fs_found ? GT1 : OUT;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                GT1: begin
                    if (take) begin
                        gt1[c] <= bin;
                        if (nx_found) begin
                            c <= nx_idx;
                        end else begin
                            c     <= fs_idx;
                            acc   <= '0;
                            k     <= KW'(EGK_ORDER);
                            state <= gt1_upd[fs_idx] ? PFX : SIGN;
`ifdef MVD_PREFIX_CHECK_EN
                            pcnt  <= '0;
`endif
                        end
                    end
                end
                PFX: begin
                    if (take) begin
                        if (bin) begin
`ifdef MVD_PREFIX_CHECK_EN
                            if (pcnt == KW'(MAX_PREFIX)) begin
                                mvd_err <= 1'b1;
                                state   <= OUT;
                            end else begin
                                acc  <= acc + (MVD_W'(1) << k);
                                k    <= k + 1'b1;
                                pcnt <= pcnt + 1'b1;
                            end
`else
                            acc <= acc + (MVD_W'(1) << k);
                            k   <= k + 1'b1;
`endif
                        end else begin
                            state <= (k == '0) ? SIGN : SFX;
                        end
                    end
                end
                SFX: begin
                    // Suffix bit weight is 2^(k-1), MSB first.
                    if (take) begin
                        acc <= acc + (MVD_W'(bin) << (k - 1'b1));
                        k   <= k - 1'b1;
                        if (k == KW'(1)) state <= SIGN;
                    end
                end
                SIGN: begin
                    if (take) begin
                        res[32'(c)*MVD_W +: MVD_W] <= sgn_v;
                        if (nx_found) begin
                            c     <= nx_idx;
                            acc   <= '0;
                            k     <= KW'(EGK_ORDER);
                            state <= gt1[nx_idx] ? PFX : SIGN;
`ifdef MVD_PREFIX_CHECK_EN
                            pcnt  <= '0;
`endif
                        end else begin
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (!mvd_err) begin
                        mvd     <= res;
                        mvd_vld <= 1'b1;
                    end
                    out_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
